// File: rtl/piece_controller_pkg.sv
// Shared types and constants for the active-piece sequencer.
package piece_controller_pkg;

  // Piece colour as handed over by the randomizer; EMPTY marks "no piece".
  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    BLK_I = 3'd1,
    BLK_O = 3'd2,
    BLK_T = 3'd3,
    BLK_S = 3'd4,
    BLK_Z = 3'd5,
    BLK_J = 3'd6,
    BLK_L = 3'd7
  } block_color;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN      = 3'd1,
    FALL       = 3'd2,
    LOCK       = 3'd3,
    WAIT_BOARD = 3'd4,
    OVER       = 3'd5
  } piece_state_t;

  localparam logic [4:0] SPAWN_X = 5'd3;
  localparam logic [4:0] SPAWN_Y = 5'd0;

  // Bit positions inside the board's can_move legality vector.
  localparam int MV_LEFT  = 4;
  localparam int MV_RIGHT = 3;
  localparam int MV_ROTR  = 2;
  localparam int MV_ROTL  = 1;
  localparam int MV_DOWN  = 0;

endpackage

// File: rtl/piece_controller_key_repeat.sv
// Frame-sampled press detect with delayed auto-repeat for one held key.
// step is a strobe valid only in the frame-pulse cycle: high on the press
// frame, then DAS_FRAMES later, then every ARR_FRAMES while still held.
module key_repeat
  import piece_controller_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic key,
  output logic step
);

  localparam int CNT_W = $clog2(DAS_FRAMES) + 1;
  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_FRAMES - 1);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_prev_q, key_prev_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             press;
  logic             repeat_tick;

  // Down-counter reloads on press (DAS) and on each repeat (ARR); terminal count fires a step.
  always_comb begin
    key_prev_d  = key_prev_q;
    rpt_cnt_d   = rpt_cnt_q;
    press       = frame_tick && key && !key_prev_q;
    repeat_tick = frame_tick && key && key_prev_q && (rpt_cnt_q == '0);
    step        = press || repeat_tick;
    if (frame_tick) begin
      key_prev_d = key;
      if (!key) begin
        rpt_cnt_d = '0;
      end else if (!key_prev_q) begin
        rpt_cnt_d = DAS_LOAD;
      end else if (rpt_cnt_q == '0) begin
        rpt_cnt_d = ARR_LOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q - CNT_ONE;
      end
    end
  end

  // Key history and repeat timer registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_prev_q <= 1'b0;
      rpt_cnt_q  <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      rpt_cnt_q  <= rpt_cnt_d;
    end
  end

endmodule

// File: rtl/piece_controller.sv
// Active tetromino sequencer: one accepted move per frame, lock hand-off to
// the board, and top-out detection.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | after reset, waiting for the first frame pulse
// SPAWN      | one Clk: load next_block at the spawn origin, ack shown
// FALL       | piece live; one action evaluated per frame pulse
// LOCK       | one Clk: get_new_block shown, board takes over
// WAIT_BOARD | waiting for a frame pulse that sees BOARD_BUSY low
// OVER       | topped out; everything frozen until Reset
module piece_controller
  import piece_controller_pkg::*;
#(
  parameter int GRAVITY_FRAMES = 30,
  parameter int DAS_FRAMES     = 10,
  parameter int ARR_FRAMES     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk_rising_edge,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rot_l,
  input  logic       key_rot_r,
  input  logic       key_down,
  input  logic [4:0] can_move,
  input  logic       BOARD_BUSY,
  input  block_color next_block,
  output logic       next_ack,
  output logic [4:0] piece_x,
  output logic [4:0] piece_y,
  output logic [1:0] piece_rot,
  output block_color piece_block,
  output logic       piece_update,
  output logic       get_new_block,
  output logic       game_over
);

  localparam int GRAV_W = $clog2(GRAVITY_FRAMES) + 1;
  localparam logic [GRAV_W-1:0] GRAV_MAX = GRAV_W'(GRAVITY_FRAMES - 1);
  localparam logic [GRAV_W-1:0] GRAV_ONE = GRAV_W'(1);

  piece_state_t      state_q, state_d;
  logic [4:0]        piece_x_q, piece_x_d;
  logic [4:0]        piece_y_q, piece_y_d;
  logic [1:0]        piece_rot_q, piece_rot_d;
  block_color        piece_block_q, piece_block_d;
  logic              next_ack_q, next_ack_d;
  logic              piece_update_q, piece_update_d;
  logic              get_new_block_q, get_new_block_d;
  logic              game_over_q, game_over_d;
  logic [GRAV_W-1:0] gravity_cnt_q, gravity_cnt_d;
  logic              rot_l_prev_q, rot_l_prev_d;
  logic              rot_r_prev_q, rot_r_prev_d;

  logic left_step;
  logic right_step;
  logic do_rot_r;
  logic do_rot_l;
  logic do_left;
  logic do_right;
  logic want_down;

  key_repeat #(
    .DAS_FRAMES(DAS_FRAMES),
    .ARR_FRAMES(ARR_FRAMES)
  ) u_rep_left (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_clk_rising_edge),
    .key        (key_left),
    .step       (left_step)
  );

  key_repeat #(
    .DAS_FRAMES(DAS_FRAMES),
    .ARR_FRAMES(ARR_FRAMES)
  ) u_rep_right (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_clk_rising_edge),
    .key        (key_right),
    .step       (right_step)
  );

  // A move qualifies only if requested alone and the board says it is legal;
  // an unqualified request falls through to the next priority level.
  assign do_rot_r  = frame_clk_rising_edge && key_rot_r && !rot_r_prev_q
                     && !key_rot_l && can_move[MV_ROTR];
  assign do_rot_l  = frame_clk_rising_edge && key_rot_l && !rot_l_prev_q
                     && !key_rot_r && can_move[MV_ROTL];
  assign do_left   = left_step && !key_right && can_move[MV_LEFT];
  assign do_right  = right_step && !key_left && can_move[MV_RIGHT];
  assign want_down = key_down || (gravity_cnt_q >= GRAV_MAX);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d         = state_q;
    piece_x_d       = piece_x_q;
    piece_y_d       = piece_y_q;
    piece_rot_d     = piece_rot_q;
    piece_block_d   = piece_block_q;
    next_ack_d      = 1'b0;
    get_new_block_d = 1'b0;
    game_over_d     = game_over_q;
    gravity_cnt_d   = gravity_cnt_q;
    rot_l_prev_d    = frame_clk_rising_edge ? key_rot_l : rot_l_prev_q;
    rot_r_prev_d    = frame_clk_rising_edge ? key_rot_r : rot_r_prev_q;

    unique case (state_q)
      IDLE: begin
        if (frame_clk_rising_edge) begin
          state_d    = SPAWN;
          next_ack_d = 1'b1;
        end
      end
      SPAWN: begin
        piece_x_d     = SPAWN_X;
        piece_y_d     = SPAWN_Y;
        piece_rot_d   = 2'd0;
        piece_block_d = next_block;
        gravity_cnt_d = '0;
        state_d       = FALL;
      end
      FALL: begin
        if (frame_clk_rising_edge) begin
          // Saturating, so a gravity step pre-empted by a move is retried next frame.
          gravity_cnt_d = (gravity_cnt_q >= GRAV_MAX) ? GRAV_MAX : gravity_cnt_q + GRAV_ONE;
          if (do_rot_r) begin
            piece_rot_d = piece_rot_q + 2'd1;
          end else if (do_rot_l) begin
            piece_rot_d = piece_rot_q - 2'd1;
          end else if (do_left) begin
            piece_x_d = piece_x_q - 5'd1;
          end else if (do_right) begin
            piece_x_d = piece_x_q + 5'd1;
          end else if (want_down) begin
            if (can_move[MV_DOWN]) begin
              piece_y_d     = piece_y_q + 5'd1;
              gravity_cnt_d = '0;
            end else if (piece_y_q == 5'd0) begin
              state_d     = OVER;
              game_over_d = 1'b1;
            end else begin
              state_d         = LOCK;
              get_new_block_d = 1'b1;
            end
          end
        end
      end
      LOCK: begin
        state_d = WAIT_BOARD;
      end
      WAIT_BOARD: begin
        // BUSY must already be low in the pulse cycle itself.
        if (frame_clk_rising_edge && !BOARD_BUSY) begin
          state_d    = SPAWN;
          next_ack_d = 1'b1;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    piece_update_d = (piece_x_d != piece_x_q) || (piece_y_d != piece_y_q)
                     || (piece_rot_d != piece_rot_q);
  end

  // State, piece and pulse registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= IDLE;
      piece_x_q       <= SPAWN_X;
      piece_y_q       <= SPAWN_Y;
      piece_rot_q     <= 2'd0;
      piece_block_q   <= EMPTY;
      next_ack_q      <= 1'b0;
      piece_update_q  <= 1'b0;
      get_new_block_q <= 1'b0;
      game_over_q     <= 1'b0;
      gravity_cnt_q   <= '0;
      rot_l_prev_q    <= 1'b0;
      rot_r_prev_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      piece_x_q       <= piece_x_d;
      piece_y_q       <= piece_y_d;
      piece_rot_q     <= piece_rot_d;
      piece_block_q   <= piece_block_d;
      next_ack_q      <= next_ack_d;
      piece_update_q  <= piece_update_d;
      get_new_block_q <= get_new_block_d;
      game_over_q     <= game_over_d;
      gravity_cnt_q   <= gravity_cnt_d;
      rot_l_prev_q    <= rot_l_prev_d;
      rot_r_prev_q    <= rot_r_prev_d;
    end
  end

  assign next_ack      = next_ack_q;
  assign piece_x       = piece_x_q;
  assign piece_y       = piece_y_q;
  assign piece_rot     = piece_rot_q;
  assign piece_block   = piece_block_q;
  assign piece_update  = piece_update_q;
  assign get_new_block = get_new_block_q;
  assign game_over     = game_over_q;

endmodule
